// File: rtl/manual_drive_fsm_if.sv
// manual_drive_fsm_if
//   Bundles the car-side levels that feed the manual-driving controller and
//   the indicator/state outputs it produces.
//   master : the surrounding car logic (drives switches, reads indicators)
//   slave  : manual_drive_fsm
//   Inputs  to slave : power_on, clutch, throttle, brake, reverse,
//                      left_btn, right_btn
//   Outputs of slave : car_state[1:0], kill, reverse_show, turn_show[1:0],
//                      mileage[MILE_W-1:0]
interface manual_drive_fsm_if #(
  parameter int MILE_W = 24
);
  logic              power_on;
  logic              clutch;
  logic              throttle;
  logic              brake;
  logic              reverse;
  logic              left_btn;
  logic              right_btn;
  logic [1:0]        car_state;
  logic              kill;
  logic              reverse_show;
  logic [1:0]        turn_show;
  logic [MILE_W-1:0] mileage;

  modport master (
    output power_on, clutch, throttle, brake, reverse, left_btn, right_btn,
    input  car_state, kill, reverse_show, turn_show, mileage
  );

  modport slave (
    input  power_on, clutch, throttle, brake, reverse, left_btn, right_btn,
    output car_state, kill, reverse_show, turn_show, mileage
  );
endinterface

// File: rtl/manual_drive_fsm.sv
// manual_drive_fsm
//   Manual-driving controller: tracks NOT_STARTING / STARTING / MOVING from
//   the driving switches, requests a stall (kill) on illegal operation,
//   blinks the turn indicators, mirrors the reverse switch and counts
//   mileage units while moving.
// Ports
//   sys_clk : single system clock
//   rst     : synchronous, active-high reset
//   io      : manual_drive_fsm_if.slave (switch levels in, indicators out)
// Parameters
//   TICK_CYCLES  : MOVING cycles per mileage unit
//   BLINK_CYCLES : half-period of the turn blink, in cycles
//   MILE_W       : mileage counter width
// All outputs come straight from registers.
module manual_drive_fsm #(
  parameter int TICK_CYCLES  = 100_000_000,
  parameter int BLINK_CYCLES = 50_000_000,
  parameter int MILE_W       = 24
) (
  input  logic               sys_clk,
  input  logic               rst,
  manual_drive_fsm_if.slave  io
);

  localparam int TW = (TICK_CYCLES  > 1) ? $clog2(TICK_CYCLES)  : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    NOT_STARTING = 2'b00,
    STARTING     = 2'b01,
    MOVING       = 2'b10
  } state_t;

  state_t            state;
  logic              killQ;
  logic              revQ;
  logic              revShowQ;
  logic [1:0]        turnQ;
  logic [MILE_W-1:0] mileQ;
  logic [TW-1:0]     tickCnt;
  logic [BW-1:0]     blinkCnt;
  logic              blinkPh;

  logic revChange;
  logic oneBtn;

  assign revChange = io.reverse != revQ;
  assign oneBtn    = io.left_btn ^ io.right_btn;

  always_ff @(posedge sys_clk) begin
    // Reverse history is kept even while unpowered so a gear change made
    // with the car off is not mistaken for one made while driving.
    revQ <= io.reverse;

    if (rst || !io.power_on) begin
      state    <= NOT_STARTING;
      killQ    <= 1'b0;
      revShowQ <= 1'b0;
      turnQ    <= 2'b00;
      mileQ    <= '0;
      tickCnt  <= '0;
      blinkCnt <= '0;
      blinkPh  <= 1'b0;
    end else begin
      killQ    <= 1'b0;
      revShowQ <= io.reverse;

      // Free-running blink prescaler; phase flips on each wrap.
      if (blinkCnt == BLINK_LAST) begin
        blinkCnt <= '0;
        blinkPh  <= ~blinkPh;
      end else begin
        blinkCnt <= blinkCnt + 1'b1;
      end

      // Hazard beats single-side turn and is shown in any state.
      if (io.left_btn && io.right_btn)
        turnQ <= 2'b11;
      else if (oneBtn && state != NOT_STARTING)
        turnQ <= {io.left_btn & blinkPh, io.right_btn & blinkPh};
      else
        turnQ <= 2'b00;

      // Mileage prescaler only runs in MOVING and keeps its partial count
      // across stops, so short hops still accumulate into whole units.
      if (state == MOVING) begin
        if (tickCnt == TICK_LAST) begin
          tickCnt <= '0;
          if (mileQ != {MILE_W{1'b1}})
            mileQ <= mileQ + 1'b1;
        end else begin
          tickCnt <= tickCnt + 1'b1;
        end
      end

      case (state)
        NOT_STARTING: begin
          // Throttle without clutch stalls the engine; it re-fires every
          // cycle it is held until power is dropped upstream.
          if (io.throttle && !io.clutch)
            killQ <= 1'b1;
          else if (io.throttle && io.clutch && !io.brake)
            state <= STARTING;
        end
        STARTING: begin
          if (io.brake)
            state <= NOT_STARTING;
          else if (io.throttle && !io.clutch)
            state <= MOVING;
        end
        MOVING: begin
          // Shifting into/out of reverse while moving without the clutch
          // stalls; checked ahead of brake so it wins a same-cycle brake.
          if (revChange && !io.clutch) begin
            killQ <= 1'b1;
            state <= NOT_STARTING;
          end else if (io.brake) begin
            state <= NOT_STARTING;
          end else if (io.clutch || !io.throttle) begin
            state <= STARTING;
          end
        end
        default: state <= NOT_STARTING;
      endcase
    end
  end

  assign io.car_state    = state;
  assign io.kill         = killQ;
  assign io.reverse_show = revShowQ;
  assign io.turn_show    = turnQ;
  assign io.mileage      = mileQ;

endmodule

// File: tb/tb_manual_drive_fsm.sv
module tb_manual_drive_fsm;
  localparam int T = 4;
  localparam int B = 2;
  localparam int W = 3;
  localparam int MAXMILE = (1 << W) - 1;

  logic sys_clk = 1'b0;
  logic rst = 1'b1;

  manual_drive_fsm_if #(.MILE_W(W)) io ();

  manual_drive_fsm #(.TICK_CYCLES(T), .BLINK_CYCLES(B), .MILE_W(W)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .io      (io)
  );

  always #5 sys_clk = ~sys_clk;

  int nVec = 0;
  int nMis = 0;

  task automatic chk(input string name, input int act, input int exp);
    nVec++;
    if (act != exp) begin
      nMis++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state as a small integer, mileage derived from the
  // total MOVING cycles since power-up, blink phase from powered-cycle count.
  typedef struct {
    int st;
    bit kill;
    bit revShow;
    int turn;
    int mile;
    int moving;
    int pc;
    bit revPrev;
    bit started;
  } mdl_t;

  mdl_t m = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

  function automatic mdl_t nextModel(mdl_t c, bit r, bit pw, bit cl, bit th,
                                     bit br, bit rv, bit lb, bit rb);
    mdl_t n;
    int ph;
    bit chg;
    n = c;
    n.started = 1;
    n.revPrev = rv;
    n.kill = 0;
    if (r || !pw) begin
      n.st = 0; n.revShow = 0; n.turn = 0; n.mile = 0; n.moving = 0; n.pc = 0;
      return n;
    end
    ph = (c.pc / B) % 2;
    if (lb && rb) n.turn = 3;
    else if ((lb != rb) && c.st != 0) n.turn = lb ? ph * 2 : ph;
    else n.turn = 0;
    n.revShow = rv;
    if (c.st == 2) n.moving = c.moving + 1;
    n.mile = (n.moving / T > MAXMILE) ? MAXMILE : n.moving / T;
    chg = rv != c.revPrev;
    case (c.st)
      0: if (th && !cl) n.kill = 1;
         else if (th && cl && !br) n.st = 1;
      1: if (br) n.st = 0;
         else if (th && !cl) n.st = 2;
      default: if (chg && !cl) begin n.kill = 1; n.st = 0; end
         else if (br) n.st = 0;
         else if (cl || !th) n.st = 1;
    endcase
    n.pc = c.pc + 1;
    return n;
  endfunction

  always @(posedge sys_clk)
    m <= nextModel(m, rst, io.power_on, io.clutch, io.throttle, io.brake,
                   io.reverse, io.left_btn, io.right_btn);

  always @(negedge sys_clk) begin
    if (m.started) begin
      chk("car_state", int'(io.car_state), m.st);
      chk("kill", int'(io.kill), int'(m.kill));
      chk("reverse_show", int'(io.reverse_show), int'(m.revShow));
      chk("turn_show", int'(io.turn_show), m.turn);
      chk("mileage", int'(io.mileage), m.mile);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  initial begin
    int smp[8];
    int cnt10;
    int r;
    io.power_on = 0; io.clutch = 0; io.throttle = 0; io.brake = 0;
    io.reverse = 0; io.left_btn = 0; io.right_btn = 0;
    rst = 1;
    step(2);
    chk("rst_state", int'(io.car_state), 0);
    chk("rst_kill", int'(io.kill), 0);
    chk("rst_mile", int'(io.mileage), 0);
    chk("rst_turn", int'(io.turn_show), 0);
    rst = 0;

    // Start sequence and mileage.
    io.power_on = 1; io.clutch = 1; io.throttle = 1;
    step(1); chk("start_starting", int'(io.car_state), 1);
    io.clutch = 0;
    step(1); chk("start_moving", int'(io.car_state), 2);
    step(8); chk("mile_after8", int'(io.mileage), 2);

    // Reverse change without clutch: stall, then held throttle re-kills.
    io.reverse = 1;
    step(1); chk("rev_kill", int'(io.kill), 1); chk("rev_kill_state", int'(io.car_state), 0);
    step(1); chk("held_kill", int'(io.kill), 1); chk("held_state", int'(io.car_state), 0);
    io.throttle = 0;
    step(1); chk("kill_drop", int'(io.kill), 0);

    // Reverse change with clutch: legal, drops to STARTING.
    io.clutch = 1; io.throttle = 1;
    step(1); chk("re_starting", int'(io.car_state), 1);
    io.clutch = 0;
    step(1); chk("re_moving", int'(io.car_state), 2);
    io.reverse = 0; io.clutch = 1;
    step(1); chk("revcl_state", int'(io.car_state), 1);
    chk("revcl_kill", int'(io.kill), 0); chk("revcl_show", int'(io.reverse_show), 0);
    io.reverse = 1;
    step(1); chk("revshow_follow", int'(io.reverse_show), 1);

    // Brake from MOVING, mileage holds, power-off clears.
    io.clutch = 0;
    step(1); chk("brk_moving", int'(io.car_state), 2);
    io.brake = 1;
    step(1); chk("brk_state", int'(io.car_state), 0);
    io.throttle = 0;
    step(3); chk("mile_hold", int'(io.mileage), 2);
    io.power_on = 0;
    step(1); chk("mile_clear", int'(io.mileage), 0);

    // Turn indicators in STARTING.
    io.brake = 0; io.power_on = 1; io.clutch = 1; io.throttle = 1;
    step(1); chk("turn_starting", int'(io.car_state), 1);
    io.clutch = 0; io.throttle = 0; io.left_btn = 1;
    cnt10 = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      smp[i] = int'(io.turn_show);
      if (smp[i] == 2) cnt10++;
    end
    chk("blink_count10", cnt10, 4);
    for (int i = 0; i < 6; i++) chk("blink_alt", int'(smp[i] != smp[i+2]), 1);
    io.right_btn = 1;
    step(1); chk("hazard", int'(io.turn_show), 3);
    io.right_btn = 0; io.brake = 1;
    step(2); chk("turn_notstart_state", int'(io.car_state), 0);
    chk("turn_notstart", int'(io.turn_show), 0);
    io.left_btn = 0;

    // Mileage saturation.
    io.brake = 0; io.clutch = 1; io.throttle = 1;
    step(1);
    io.clutch = 0;
    step(40); chk("mile_sat", int'(io.mileage), MAXMILE);

    // Reverse change beats brake in MOVING.
    io.reverse = 0; io.brake = 1;
    step(1); chk("prio_kill", int'(io.kill), 1); chk("prio_state", int'(io.car_state), 0);
    io.throttle = 0; io.brake = 0;
    step(1);

    // Randomized phase: mostly slow-changing levels so MOVING runs long.
    for (int i = 0; i < 3000; i++) begin
      rst = 0;
      r = int'($urandom_range(0, 15));
      case (r)
        0: rst = ($urandom_range(0, 7) == 0);
        1: io.power_on = ($urandom_range(0, 5) != 0);
        2: io.clutch = ~io.clutch;
        3: io.throttle = ~io.throttle;
        4: io.brake = ($urandom_range(0, 2) == 0);
        5: io.reverse = ~io.reverse;
        6: io.left_btn = ~io.left_btn;
        7: io.right_btn = ~io.right_btn;
        default: ;
      endcase
      step(1);
    end

    step(1);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
